// File: rtl/axi4_slave_ram.sv
// AXI4-full slave backed by a 64-bit dual-port word array.
// Write and read channels run independent FSMs. The read data path is a two-stage pipeline.
module axi4_slave_ram #(
    parameter logic [31:0] C_S_BASE_ADDR      = 32'h00000000,
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_MEM_DEPTH_LOG2   = 12
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IW = AW - 3;
    localparam int unsigned DL = C_MEM_DEPTH_LOG2;
    localparam int unsigned NB = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [AW-1:0] BASE = AW'(C_S_BASE_ADDR);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [2**C_MEM_DEPTH_LOG2];

    // Returns {below_base, word_index}. The borrow of the offset subtraction flags addresses under the base.
    function automatic logic [IW:0] decode(input logic [AW-1:0] addr);
        logic [AW:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE};
        return {diff[AW], IW'(diff[AW-1:0] >> 3)};
    endfunction

    logic unused;
    assign unused = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

    w_state_t                    w_state, w_next;
    logic [IW-1:0]               w_idx;
    logic                        w_below, w_err;
    logic [7:0]                  w_len;
    logic [1:0]                  w_burst;
    logic [8:0]                  w_cnt;
    logic                        aw_hs, w_hs, b_hs, w_oob, w_in_len, w_bad_len, w_we, w_err_n;

    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign b_hs      = S_AXI_BVALID && S_AXI_BREADY;
    assign w_oob     = w_below || (|w_idx[IW-1:DL]);
    assign w_in_len  = w_cnt <= {1'b0, w_len};
    assign w_bad_len = S_AXI_WLAST ? (w_cnt != {1'b0, w_len}) : (w_cnt == {1'b0, w_len});
    assign w_we      = w_hs && w_in_len && !w_oob;
    assign w_err_n   = w_err || w_oob || w_bad_len;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && S_AXI_WLAST) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= '0;
            w_idx         <= '0;
            w_below       <= 1'b0;
            w_len         <= '0;
            w_burst       <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
        end else begin
            S_AXI_AWREADY <= (w_next == W_IDLE);
            S_AXI_WREADY  <= (w_next == W_DATA);
            S_AXI_BVALID  <= (w_next == W_RESP);
            if (aw_hs) begin
                {w_below, w_idx} <= decode(S_AXI_AWADDR);
                w_len     <= S_AXI_AWLEN;
                w_burst   <= S_AXI_AWBURST;
                w_cnt     <= '0;
                w_err     <= 1'b0;
                S_AXI_BID <= S_AXI_AWID;
            end
            if (w_hs) begin
                w_err <= w_err_n;
                if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
                if (w_burst != 2'b00) w_idx <= w_idx + IW'(1);
                if (S_AXI_WLAST) S_AXI_BRESP <= w_err_n ? 2'b10 : 2'b00;
            end
        end
    end

    r_state_t                      r_state, r_next;
    logic [IW-1:0]                 r_idx;
    logic                          r_below;
    logic [7:0]                    r_len;
    logic [1:0]                    r_burst;
    logic [8:0]                    r_cnt;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_id;
    logic [C_S_AXI_DATA_WIDTH-1:0] s1_data;
    logic                          s1_valid, s1_err, s1_last;
    logic                          ar_hs, r_hs, r_oob, out_free, s1_free, r_issue;

    assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs     = S_AXI_RVALID && S_AXI_RREADY;
    assign r_oob    = r_below || (|r_idx[IW-1:DL]);
    assign out_free = !S_AXI_RVALID || S_AXI_RREADY;
    assign s1_free  = !s1_valid || out_free;
    assign r_issue  = (r_state == R_DATA) && (r_cnt <= {1'b0, r_len}) && s1_free;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && S_AXI_RLAST) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Stage 1 holds the RAM output and only advances when the output register frees up.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= '0;
            S_AXI_RID     <= '0;
            r_idx         <= '0;
            r_below       <= 1'b0;
            r_len         <= '0;
            r_burst       <= '0;
            r_cnt         <= '0;
            r_id          <= '0;
            s1_valid      <= 1'b0;
            s1_err        <= 1'b0;
            s1_last       <= 1'b0;
        end else begin
            S_AXI_ARREADY <= (r_next == R_IDLE);
            if (ar_hs) begin
                {r_below, r_idx} <= decode(S_AXI_ARADDR);
                r_len   <= S_AXI_ARLEN;
                r_burst <= S_AXI_ARBURST;
                r_cnt   <= '0;
                r_id    <= S_AXI_ARID;
            end
            if (r_issue) begin
                s1_valid <= 1'b1;
                s1_err   <= r_oob;
                s1_last  <= (r_cnt == {1'b0, r_len});
                r_cnt    <= r_cnt + 9'd1;
                if (r_burst != 2'b00) r_idx <= r_idx + IW'(1);
            end else if (out_free) begin
                s1_valid <= 1'b0;
            end
            if (out_free) begin
                if (s1_valid) begin
                    S_AXI_RVALID <= 1'b1;
                    S_AXI_RDATA  <= s1_err ? '0 : s1_data;
                    S_AXI_RRESP  <= s1_err ? 2'b10 : 2'b00;
                    S_AXI_RLAST  <= s1_last;
                    S_AXI_RID    <= r_id;
                end else begin
                    S_AXI_RVALID <= 1'b0;
                    S_AXI_RLAST  <= 1'b0;
                end
            end
        end
    end

    // Read and write in one block: a same-cycle collision returns the old word.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx[DL-1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
        if (r_issue) s1_data <= mem[r_idx[DL-1:0]];
    end

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Directed bench for axi4_slave_ram: a word-array model predicts every B and R beat,
// and a single monitor compares them on each falling edge.
module tb_axi4_slave_ram;
    localparam logic [31:0] BASE  = 32'h00000000;
    localparam int          DEPTH = 4096;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [0:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
    logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN, S_AXI_WSTRB;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
    logic [63:0] S_AXI_WDATA, S_AXI_RDATA;

    always #5 i_clk = ~i_clk;

    axi4_slave_ram #(
        .C_S_BASE_ADDR(BASE), .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(64), .C_MEM_DEPTH_LOG2(12)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic id; } rbeat_t;
    typedef struct { logic [1:0] resp; logic id; } bresp_t;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] mm [DEPTH];
    logic [63:0] wd [256];
    logic [63:0] got [256];
    logic [1:0]  got_resp [256];
    int          got_n, lat;
    logic [1:0]  last_bresp;
    rbeat_t      exp_r [$];
    bresp_t      exp_b [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Monitor: every R/B handshake is matched against the model queues; stalled R beats must not change.
    initial begin
        logic        hold;
        logic [63:0] h_data;
        logic [1:0]  h_resp;
        logic        h_last;
        rbeat_t      e;
        bresp_t      eb;
        hold = 1'b0;
        h_data = '0; h_resp = '0; h_last = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("r_stall_valid", S_AXI_RVALID, 1);
                    chk("r_stall_data", S_AXI_RDATA, h_data);
                    chk("r_stall_resp", S_AXI_RRESP, h_resp);
                    chk("r_stall_last", S_AXI_RLAST, h_last);
                end
                hold   = S_AXI_RVALID && !S_AXI_RREADY;
                h_data = S_AXI_RDATA;
                h_resp = S_AXI_RRESP;
                h_last = S_AXI_RLAST;
                if (S_AXI_RVALID && S_AXI_RREADY) begin
                    if (exp_r.size() == 0) begin
                        fail_now("r_unexpected_beat");
                    end else begin
                        e = exp_r.pop_front();
                        chk("r_data", S_AXI_RDATA, e.data);
                        chk("r_resp", S_AXI_RRESP, e.resp);
                        chk("r_last", S_AXI_RLAST, e.last);
                        chk("r_id", S_AXI_RID, e.id);
                    end
                end
                if (S_AXI_BVALID && S_AXI_BREADY) begin
                    last_bresp = S_AXI_BRESP;
                    if (exp_b.size() == 0) begin
                        fail_now("b_unexpected");
                    end else begin
                        eb = exp_b.pop_front();
                        chk("b_resp", S_AXI_BRESP, eb.resp);
                        chk("b_id", S_AXI_BID, eb.id);
                    end
                end
            end
        end
    end

    task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic id);
        int n;
        S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst; S_AXI_AWID = id;
        S_AXI_AWSIZE = 3'd3; S_AXI_AWVALID = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (S_AXI_AWREADY) break;
        end
        if (n == 100) fail_now("aw_timeout");
        @(posedge i_clk); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (S_AXI_WREADY) break;
        end
        if (n == 100) fail_now("w_timeout");
        @(posedge i_clk); #1;
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic id,
                             input logic [7:0] strb, input int nbeats, input int last_at);
        longint off, idx;
        logic   err;
        int     n;
        off = longint'(addr) - longint'(BASE);
        err = (last_at != len);
        for (int b = 0; b < nbeats; b++) begin
            idx = off / 8 + ((burst == 2'b00) ? 0 : b);
            if (off < 0 || idx >= DEPTH) err = 1'b1;
            else if (b <= len)
                for (int l = 0; l < 8; l++) if (strb[l]) mm[idx][8*l +: 8] = wd[b][8*l +: 8];
        end
        exp_b.push_back('{err ? 2'b10 : 2'b00, id});
        aw_phase(addr, 8'(len), burst, id);
        for (int b = 0; b < nbeats; b++) w_beat(wd[b], strb, b == last_at);
        S_AXI_BREADY = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (S_AXI_BVALID) break;
        end
        if (n == 100) fail_now("b_timeout");
        @(posedge i_clk); #1;
        S_AXI_BREADY = 1'b0;
        chk("b_pending", exp_b.size(), 0);
        exp_b.delete();
    endtask

    // mode 0: RREADY always high; mode 1: RREADY pattern 1,0,0 repeating.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic id, input int mode);
        longint off, idx;
        logic   oob, done;
        int     n, cyc;
        off = longint'(addr) - longint'(BASE);
        for (int b = 0; b <= len; b++) begin
            idx = off / 8 + ((burst == 2'b00) ? 0 : b);
            oob = (off < 0 || idx >= DEPTH);
            exp_r.push_back('{oob ? 64'd0 : mm[idx], oob ? 2'b10 : 2'b00, b == len, id});
        end
        S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARBURST = burst; S_AXI_ARID = id;
        S_AXI_ARSIZE = 3'd3; S_AXI_ARVALID = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (S_AXI_ARREADY) break;
        end
        if (n == 100) fail_now("ar_timeout");
        @(posedge i_clk); #1;
        S_AXI_ARVALID = 1'b0;
        got_n = 0; lat = -1; done = 1'b0;
        for (cyc = 0; cyc < 400 && !done; cyc++) begin
            S_AXI_RREADY = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            @(negedge i_clk);
            if (S_AXI_RVALID && lat < 0) lat = cyc;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                got[got_n] = S_AXI_RDATA;
                got_resp[got_n] = S_AXI_RRESP;
                got_n++;
                done = S_AXI_RLAST;
            end
            @(posedge i_clk); #1;
        end
        S_AXI_RREADY = 1'b0;
        if (!done) fail_now("r_timeout");
        chk("r_first_latency", lat, 2);
        chk("r_beat_count", got_n, len + 1);
        chk("r_pending", exp_r.size(), 0);
        exp_r.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal;
    end

    initial begin
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0;
        S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
        S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        last_bresp = 2'b11;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;

        // Reset values
        #20;
        chk("rst_awready", S_AXI_AWREADY, 0);
        chk("rst_wready", S_AXI_WREADY, 0);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_arready", S_AXI_ARREADY, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_rlast", S_AXI_RLAST, 0);
        chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_ids", {S_AXI_BID, S_AXI_RID}, 0);
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_awready", S_AXI_AWREADY, 1);
        chk("post_rst_arready", S_AXI_ARREADY, 1);
        @(posedge i_clk); #1;

        // 16-beat INCR write then read
        for (int i = 0; i < 16; i++) wd[i] = 64'h1000 + 64'(i);
        axi_write(32'h0, 15, 2'b01, 1'b1, 8'hFF, 16, 15);
        chk("lit_bresp_okay", last_bresp, 2'b00);
        axi_read(32'h0, 15, 2'b01, 1'b1, 0);
        chk("lit_beat0", got[0], 64'h1000);
        chk("lit_beat15", got[15], 64'h100F);

        // Partial strobe over a preloaded word
        wd[0] = 64'hFFFFFFFF_FFFFFFFF;
        axi_write(32'h8, 0, 2'b01, 1'b0, 8'hFF, 1, 0);
        wd[0] = 64'hAAAAAAAA_BBBBBBBB;
        axi_write(32'h8, 0, 2'b01, 1'b0, 8'h0F, 1, 0);
        axi_read(32'h8, 0, 2'b01, 1'b0, 0);
        chk("lit_strobe_merge", got[0], 64'hFFFFFFFF_BBBBBBBB);

        // 8-beat read with RREADY stalls
        axi_read(32'h0, 7, 2'b10, 1'b1, 1);
        chk("lit_stall_beat1", got[1], 64'hFFFFFFFF_BBBBBBBB);
        chk("lit_stall_beat7", got[7], 64'h1007);

        // Out-of-range write and read (index 4096)
        for (int i = 0; i < 4; i++) wd[i] = 64'hDEAD_0000 + 64'(i);
        axi_write(32'h8000, 3, 2'b01, 1'b0, 8'hFF, 4, 3);
        chk("lit_oob_bresp", last_bresp, 2'b10);
        axi_read(32'h8000, 3, 2'b01, 1'b0, 0);
        chk("lit_oob_rdata", got[0], 64'd0);
        chk("lit_oob_rresp", got_resp[3], 2'b10);
        axi_read(32'h0, 0, 2'b01, 1'b0, 0);
        chk("lit_no_alias_word0", got[0], 64'h1000);

        // FIXED burst lands every beat on one word
        for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
        axi_write(32'h10, 3, 2'b00, 1'b0, 8'hFF, 4, 3);
        axi_read(32'h10, 1, 2'b01, 1'b0, 0);
        chk("lit_fixed_word2", got[0], 64'd4);
        chk("lit_fixed_word3", got[1], 64'h1003);

        // WLAST early (beat 2 of LEN=3) and late (beat 2 of LEN=1)
        for (int i = 0; i < 3; i++) wd[i] = 64'h50 + 64'(i);
        axi_write(32'h20, 3, 2'b01, 1'b0, 8'hFF, 3, 2);
        chk("lit_early_wlast_bresp", last_bresp, 2'b10);
        axi_write(32'h40, 1, 2'b01, 1'b1, 8'hFF, 3, 2);
        chk("lit_late_wlast_bresp", last_bresp, 2'b10);
        axi_read(32'h40, 2, 2'b01, 1'b0, 0);
        chk("lit_late_word8", got[0], 64'h50);
        chk("lit_late_word10", got[2], 64'h100A);

        // Reset in the middle of a 16-beat write
        aw_phase(32'h200, 8'd15, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) w_beat(64'h9000 + 64'(i), 8'hFF, 1'b0);
        S_AXI_WDATA = 64'h9005; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge i_clk);
        chk("mid_wready_before_rst", S_AXI_WREADY, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_wready", S_AXI_WREADY, 0);
        chk("mid_rst_bvalid", S_AXI_BVALID, 0);
        S_AXI_WVALID = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("mid_post_awready", S_AXI_AWREADY, 1);
        chk("mid_post_bvalid", S_AXI_BVALID, 0);
        @(posedge i_clk); #1;
        S_AXI_BREADY = 1'b0;
        wd[0] = 64'h77; wd[1] = 64'h78;
        axi_write(32'h300, 1, 2'b01, 1'b1, 8'hFF, 2, 1);
        chk("lit_after_rst_bresp", last_bresp, 2'b00);
        axi_read(32'h300, 1, 2'b01, 1'b1, 0);
        chk("lit_after_rst_word", got[1], 64'h78);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
